// File: rtl/kgp_fetch_pkg.sv
// Shared types and constants for the KGP-RISC fetch controller.
package kgp_fetch_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned PC_INC = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_bundle_t;

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-to-decode valid/ready handoff of one instruction word and its PC.
interface fetch_controller_if;
  import kgp_fetch_pkg::*;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;

  modport master (output out_valid, output out_instr, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);
endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry flushable FIFO decoupling out_ready from the PC enable.
module fetch_skid_fifo
  import kgp_fetch_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_bundle_t push_data,
  input  logic          pop,
  input  logic          flush,
  output logic          valid,
  output logic          full,
  output fetch_bundle_t head
);

  fetch_bundle_t mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;

  // Storage, pointers and occupancy; flush drops both entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign valid = (count != 2'd0);
  assign full  = (count == 2'd2);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_controller.sv
// KGP-RISC fetch controller: owns the PC, drives instruction memory and
// hands fetched words to decode. Optional macro FETCH_SKID_EN replaces the
// single output register with a 2-entry skid FIFO.
module fetch_controller
  import kgp_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [XLEN-1:0]   imem_addr,
  input  logic [XLEN-1:0]   imem_instr,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_target,
  input  logic              halt_req,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_cnt,
  fetch_controller_if.master dec
);

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic [XLEN-1:0] pc;
  logic            redirect_c;
  logic            capture_c;
  logic            handoff_c;
  logic            slot_free_c;

  assign imem_addr = pc;
  assign handoff_c = dec.out_valid & dec.out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state; a same-cycle redirect cancels a halt from the wrong path.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  state_next = ST_FETCH;
      ST_FETCH: if (!redirect_valid && halt_req) state_next = ST_HALT;
      default:  state_next = state;
    endcase
  end

  // Control decode: redirect wins over capture; HALT ignores redirects.
  always_comb begin
    redirect_c = 1'b0;
    capture_c  = 1'b0;
    redirect_c = redirect_valid && (state != ST_HALT);
    capture_c  = (state == ST_FETCH) && !redirect_valid && slot_free_c;
  end

  // Program counter.
  always_ff @(posedge clk) begin
    if (rst)             pc <= RESET_PC;
    else if (redirect_c) pc <= redirect_target & ~32'h3;
    else if (capture_c)  pc <= pc + XLEN'(PC_INC);
  end

`ifdef FETCH_SKID_EN
  fetch_bundle_t cap_data;
  fetch_bundle_t head;
  logic          fifo_full;

  assign slot_free_c = !fifo_full;
  assign cap_data    = '{instr: imem_instr, pc: pc};

  fetch_skid_fifo u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (capture_c),
    .push_data (cap_data),
    .pop       (handoff_c),
    .flush     (redirect_c),
    .valid     (dec.out_valid),
    .full      (fifo_full),
    .head      (head)
  );

  assign dec.out_instr = head.instr;
  assign dec.out_pc    = head.pc;
`else
  assign slot_free_c = !dec.out_valid | dec.out_ready;

  // Single output slot: flush, capture, or drain on handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec.out_valid <= 1'b0;
      dec.out_instr <= '0;
      dec.out_pc    <= '0;
    end else if (redirect_c) begin
      dec.out_valid <= 1'b0;
    end else if (capture_c) begin
      dec.out_valid <= 1'b1;
      dec.out_instr <= imem_instr;
      dec.out_pc    <= pc;
    end else if (handoff_c) begin
      dec.out_valid <= 1'b0;
    end
  end
`endif

  // Halt flag and saturating handoff counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted    <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      halted <= (state_next == ST_HALT);
      if (handoff_c && (fetch_cnt != {CNT_W{1'b1}}))
        fetch_cnt <= fetch_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: random handshake/redirect traffic against a
// queue-based model, plus a small-counter instance for wrap and saturation.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_instr;
  logic        redirect_valid, halt_req, halted;
  logic [31:0] redirect_target;
  logic [15:0] fetch_cnt;

  logic        rst2;
  logic [31:0] imem_addr2, imem_instr2;
  logic        halted2;
  logic [1:0]  fetch_cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_controller_if dif ();
  fetch_controller_if dif2 ();

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign imem_instr  = mem_word(imem_addr);
  assign imem_instr2 = mem_word(imem_addr2);

  fetch_controller #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt_req(halt_req), .halted(halted), .fetch_cnt(fetch_cnt), .dec(dif)
  );

  fetch_controller #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .imem_addr(imem_addr2), .imem_instr(imem_instr2),
    .redirect_valid(1'b0), .redirect_target(32'h0),
    .halt_req(1'b0), .halted(halted2), .fetch_cnt(fetch_cnt2), .dec(dif2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: next address to fetch, visible slot contents as a
  // queue of PCs, whether fetching has started, and whether halted.
  int unsigned m_pc;
  int unsigned slot[$];
  bit          m_started;
  bit          m_halt;
  int unsigned m_cnt;

  task automatic cycle(input bit r, input bit rv, input logic [31:0] tgt,
                       input bit hr, input bit rdy);
    @(negedge clk);
    rst = r; redirect_valid = rv; redirect_target = tgt; halt_req = hr;
    dif.out_ready = rdy;
    if (r) begin
      m_pc = 32'h0; slot.delete(); m_cnt = 0; m_started = 0; m_halt = 0;
    end else begin
      if (slot.size() > 0 && rdy) begin
        void'(slot.pop_front());
        if (m_cnt < 65535) m_cnt++;
      end
      if (rv && !m_halt) begin
        m_pc = tgt & ~32'h3;
        slot.delete();
        m_started = 1;
      end else if (m_halt) begin
        // frozen: only draining happens
      end else if (!m_started) begin
        m_started = 1;
      end else begin
        if (slot.size() == 0) begin
          slot.push_back(m_pc);
          m_pc = m_pc + 4;
        end
        if (hr) m_halt = 1;
      end
    end
    @(posedge clk);
    #1;
    check("imem_addr", imem_addr, m_pc);
    check("out_valid", 32'(dif.out_valid), 32'(slot.size() != 0));
    if (slot.size() != 0) begin
      check("out_pc", dif.out_pc, slot[0]);
      check("out_instr", dif.out_instr, mem_word(slot[0]));
    end
    check("fetch_cnt", 32'(fetch_cnt), m_cnt);
    check("halted", 32'(halted), 32'(m_halt));
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0; halt_req = 1'b0;
    dif.out_ready = 1'b0;
    rst2 = 1'b1; dif2.out_ready = 1'b1;

    // Reset state
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1);
    check("rst_out_instr", dif.out_instr, 32'h0);
    check("rst_out_pc", dif.out_pc, 32'h0);

    // Streaming from reset, then a 4-cycle stall holding PC 8
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
    check("stream_pc8", dif.out_pc, 32'h8);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);

    // Redirect while an entry is pending and not accepted
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 32'h0000_0043, 0, 0);
    check("redir_bubble", 32'(dif.out_valid), 32'h0);
    cycle(0, 0, 0, 0, 1);
    check("redir_target", dif.out_pc, 32'h40);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);

    // Redirect and halt together: redirect wins, fetching continues
    cycle(0, 1, 32'h0000_0100, 1, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
    check("redir_halt_nohalt", 32'(halted), 32'h0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      bit rv;
      bit rdy;
      rv  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      cycle(0, rv, $urandom, 0, rdy);
    end

    // Reset during a redirect
    cycle(1, 1, 32'h0000_0200, 1, 1);
    check("rst_redir_addr", imem_addr, 32'h0);
    check("rst_redir_valid", 32'(dif.out_valid), 32'h0);
    check("rst_redir_cnt", 32'(fetch_cnt), 32'h0);

    // Halt with a pending entry held by out_ready=0
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 32'h0000_0300, 0, 0);
    check("halt_flag", 32'(halted), 32'h1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
    check("halt_drained", 32'(dif.out_valid), 32'h0);
    check("halt_cnt", 32'(fetch_cnt), 32'h1);

    // Wrap from FFFF_FFF8 and saturation of a 2-bit counter
    @(negedge clk); rst2 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("wrap_pc0", dif2.out_pc, 32'hFFFF_FFF8);
    check("wrap_instr0", dif2.out_instr, mem_word(32'hFFFF_FFF8));
    @(posedge clk); #1;
    check("wrap_pc1", dif2.out_pc, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check("wrap_pc2", dif2.out_pc, 32'h0000_0000);
    check("wrap_instr2", dif2.out_instr, 32'h1000_0000);
    check("cnt2_before_sat", 32'(fetch_cnt2), 32'h2);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
    end
    check("cnt2_sat", 32'(fetch_cnt2), 32'h3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
